// File: rtl/intctrl_pkg.sv
// Shared interrupt-controller definitions: register addresses, vector width, service FSM states.
// Pure declarations; no logic.
package intctrl_pkg;
    localparam logic [15:0] STATUS_ADDR_DEF = 16'h00EF;
    localparam logic [15:0] CLEAR_ADDR_DEF  = 16'h00FF;
    localparam int          VEC_W           = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_PRESENT,
        S_CLR,
        S_WAIT_DONE
    } state_t;
endpackage

// File: rtl/intsvc_master_prio_enc8.sv
// Lowest-set-bit encoder: bit 0 wins. Purely combinational, zero latency, no flow control.
module prio_enc8 (
    input  logic [7:0] i_vec,
    output logic [2:0] o_idx,
    output logic       o_any
);
    always_comb begin
        o_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i_vec[i]) o_idx = 3'(i);
        end
    end

    assign o_any = |i_vec;
endmodule

// File: rtl/intsvc_master.sv
// Interrupt service initiator: reads intctrl status, presents the top source to the CPU, clears it.
// irq->int_req READ_LAT+2 cycles; holds int_req until int_ack, waits for int_done before re-arming.
module intsvc_master
    import intctrl_pkg::*;
#(
    parameter logic [15:0] STATUS_ADDR = STATUS_ADDR_DEF,
    parameter logic [15:0] CLEAR_ADDR  = CLEAR_ADDR_DEF,
    parameter int          READ_LAT    = 1,
    parameter int          WR_HOLD     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq_i,
    output logic [15:0]       address_o,
    output logic              rd_o,
    output logic              wr_o,
    output logic [VEC_W-1:0]  data_o,
    input  logic [VEC_W-1:0]  data_i,
    output logic              bus_busy_o,
    output logic              int_req_o,
    output logic [2:0]        int_num_o,
    input  logic              int_ack_i,
    input  logic              int_done_i,
    output logic [7:0]        spurious_o
);
    localparam logic [2:0] RL_C = 3'(READ_LAT);
    localparam logic [2:0] WH_C = 3'(WR_HOLD);

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic [VEC_W-1:0] r_status;
    logic             r_done_sticky;
    logic [15:0]      r_addr;
    logic             r_rd;
    logic             r_wr;
    logic [VEC_W-1:0] r_data;
    logic             r_busy;
    logic             r_req;
    logic [2:0]       r_num;
    logic [7:0]       r_spur;

    logic [2:0]       w_idx;
    logic             w_any;

    prio_enc8 u_prio (
        .i_vec (r_status),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 3'd0;
            r_status      <= '0;
            r_done_sticky <= 1'b0;
            r_addr        <= 16'h0000;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_data        <= '0;
            r_busy        <= 1'b0;
            r_req         <= 1'b0;
            r_num         <= 3'd0;
            r_spur        <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (irq_i) begin
                        r_state <= S_RD;
                        r_busy  <= 1'b1;
                    end
                end
                S_RD: begin
                    if (!r_rd) begin
                        r_rd   <= 1'b1;
                        r_addr <= STATUS_ADDR;
                        r_cnt  <= 3'd1;
                    end else if (r_cnt == RL_C) begin
                        r_status <= data_i;
                        r_rd     <= 1'b0;
                        r_addr   <= 16'h0000;
                        r_state  <= S_CAP;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_CAP: begin
                    if (!w_any) begin
                        if (r_spur != 8'hFF) r_spur <= r_spur + 8'd1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_num   <= w_idx;
                        r_req   <= 1'b1;
                        r_state <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (int_done_i) r_done_sticky <= 1'b1;
                    if (int_ack_i) begin
                        r_req   <= 1'b0;
                        r_addr  <= CLEAR_ADDR;
                        r_wr    <= 1'b1;
                        r_data  <= r_status & ~(VEC_W'(1) << r_num);
                        r_cnt   <= 3'd1;
                        r_state <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (int_done_i) r_done_sticky <= 1'b1;
                    if (r_cnt == WH_C) begin
                        r_wr    <= 1'b0;
                        r_addr  <= 16'h0000;
                        r_data  <= '0;
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_WAIT_DONE: begin
                    // An early done was already latched, so this state can exit at once.
                    if (int_done_i || r_done_sticky) begin
                        r_done_sticky <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                    r_req   <= 1'b0;
                    r_addr  <= 16'h0000;
                end
            endcase
        end
    end

    assign address_o  = r_addr;
    assign rd_o       = r_rd;
    assign wr_o       = r_wr;
    assign data_o     = r_data;
    assign bus_busy_o = r_busy;
    assign int_req_o  = r_req;
    assign int_num_o  = r_num;
    assign spurious_o = r_spur;
endmodule

// File: doc/intsvc_master.md
# intsvc_master

Bus-initiator end of the interrupt path: sits between the `intctrl` register responder and the CPU core. On an interrupt it reads the pending-status register, picks the highest-priority source, and hands its number to the CPU with a request/acknowledge handshake. It then writes the clear register to retire that one source and waits for the CPU's end-of-service before re-arming. It owns the address/data bus only while servicing; the top-level bus mux grants it via `bus_busy_o`.

## Interface

**Parameters**
- `STATUS_ADDR`, default 16'h00EF: address of the intctrl pending-status register (read).
- `CLEAR_ADDR`, default 16'h00FF: address of the intctrl clear register (write).
- `READ_LAT`, default 1: cycles from address/`rd_o` assertion to valid `data_i`; legal range 1..3.
- `WR_HOLD`, default 2: cycles `wr_o`, address and data are held; legal range 1..4.

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `irq_i`, in, 1: level, high while any intctrl pending bit is set.
- `address_o`, out, 16: bus address; 16'h0000 when not driving.
- `rd_o`, out, 1: bus read strobe.
- `wr_o`, out, 1: bus write strobe; also the tri-state enable for `data_o` at top level.
- `data_o`, out, 8: write data.
- `data_i`, in, 8: read data.
- `bus_busy_o`, out, 1: high in every non-IDLE state.
- `int_req_o`, out, 1: interrupt request to CPU.
- `int_num_o`, out, 3: serviced source index; valid while `int_req_o` is high.
- `int_ack_i`, in, 1: CPU accepted the request.
- `int_done_i`, in, 1: CPU finished the service routine.
- `spurious_o`, out, 8: saturating count of status reads that returned 0.

## Operation

**Priority:** bit 0 is highest. `int_num_o` is the index of the lowest set bit of the captured status.

**FSM states:** IDLE, RD, CAP, PRESENT, CLR, WAIT_DONE.
- **IDLE:** when `irq_i` is 1, go to RD.
- **RD:** drive `STATUS_ADDR` and `rd_o`=1 for `READ_LAT` cycles, then go to CAP.
- **CAP:** register `data_i` into `status_q`.
  - `status_q`==0: increment `spurious_o` (holds at 255) and go to IDLE.
  - Otherwise: register the priority index and go to PRESENT.
- **PRESENT:** `int_req_o`=1 with `int_num_o` stable. Hold until `int_ack_i`=1 is sampled, then go to CLR. Deassert `int_req_o` the cycle after the ack.
- **CLR:** drive `CLEAR_ADDR`, `wr_o`=1, `data_o` = `status_q` & ~(1<<`int_num_o`) for `WR_HOLD` cycles. intctrl ANDs its pending bits with the written value, so only the serviced source is retired. Then go to WAIT_DONE.
- **WAIT_DONE:** wait for `int_done_i`=1, then go to IDLE.

**Boundary conditions**
- A new source arriving during service stays pending in intctrl. `irq_i` stays high, so it is picked up by a fresh status read after IDLE; a stale `status_q` is never reused.
- `int_done_i` arriving early, in PRESENT or CLR, is latched into a sticky flag. WAIT_DONE then exits in one cycle. The flag clears on leaving WAIT_DONE.
- `int_ack_i` and `int_done_i` in the same cycle while in PRESENT: the ack is taken and done is latched.
- `irq_i` falling while in RD: the read completes, and a 0 result counts as spurious.
- `reset` mid-transaction:
  - All outputs drop immediately (asynchronous).
  - FSM goes to IDLE, `status_q`=0, sticky flag=0, `spurious_o`=0.
  - No partial clear is retried.

## Timing

**Reset values:** `address_o`=0, `rd_o`=0, `wr_o`=0, `data_o`=0, `bus_busy_o`=0, `int_req_o`=0, `int_num_o`=0, `spurious_o`=0.

- All outputs are registered.
- `irq_i` sampled high at edge N puts address/`rd_o` valid after edge N+1.
- `data_i` is captured at edge N+1+`READ_LAT`, and `int_req_o` rises after edge N+2+`READ_LAT`.
- Minimum latency from `irq_i` to `int_req_o` is `READ_LAT`+2 cycles, i.e. 3 at default.
- One full service takes at least `READ_LAT`+`WR_HOLD`+5 cycles.
- Bus address changes only on state entry; `rd_o` and `wr_o` are never high together.

## Structure

- Shared package `intctrl_pkg`:
  - `STATUS_ADDR` and `CLEAR_ADDR` defaults, shared with intctrl.
  - Vector width constant 8.
  - FSM state enum.
- Sub-module `prio_enc8`: combinational lowest-set-bit encoder, 8-bit in, 3-bit index plus `any` out.
- The FSM, bus drive and counter live in the top module.

## Test plan

1. Status 8'h01, ack 2 cycles after the request, done 5 cycles later → `int_num_o`=0, clear write `data_o`=8'h00 at 16'h00FF held 2 cycles, back to IDLE.
2. Status 8'hA4 → `int_num_o`=2 and clear data 8'hA0. `irq_i` stays high, so the second pass gives `int_num_o`=5 with clear data 8'h80; the third pass gives 7 with clear data 8'h00.
3. `irq_i` pulse with status read 8'h00 → no `int_req_o`; `spurious_o` goes 0→1. After 300 such pulses `spurious_o` holds at 255.
4. `int_done_i` pulsed in the same cycle as `int_ack_i` → WAIT_DONE lasts exactly 1 cycle, and the next `irq_i` is serviced normally.
5. `reset` asserted in CLR on the first `wr_o` cycle → `wr_o`, `bus_busy_o` and `address_o` go to 0 before the next edge. After release the FSM is in IDLE and re-services the still-pending source.
6. `READ_LAT`=3 build with status 8'h10 → `rd_o` high 3 cycles, `int_req_o` 5 cycles after `irq_i` is sampled, `int_num_o`=4.
